// File: rtl/fft_r22sdf_pkg.sv
// Shared types, constants and helpers for the radix-2^2 SDF FFT butterflies.
package fft_r22sdf_pkg;

  localparam int CPX_MAX_W         = 64;
  localparam int INLINE_DELAY_MAX  = 32;
  localparam int DEFAULT_BF2_DEPTH = 256;
  localparam int DEFAULT_BF1_DEPTH = 2 * DEFAULT_BF2_DEPTH;

  // Wide complex carrier; callers zero- or sign-extend and truncate back, which keeps -x exact mod 2^W.
  typedef struct packed {
    logic [CPX_MAX_W-1:0] re;
    logic [CPX_MAX_W-1:0] im;
  } cpx_wide_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  function automatic int bf1Depth(input int depth);
    return 2 * depth;
  endfunction

  function automatic int bf2Depth(input int depth);
    return depth / 2;
  endfunction

  function automatic cpx_wide_t rotMinusJ(input cpx_wide_t x);
    cpx_wide_t r;
    r.re = x.im;
    r.im = -x.re;
    return r;
  endfunction

endpackage

// File: rtl/fft_r22sdf_ctr.sv
// Valid-sample counter over a 4*DEPTH window producing butterfly-select and -j rotate controls.
module fft_r22sdf_ctr
  import fft_r22sdf_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sel_o,
  output logic rot_o
);

  localparam int K     = clog2(DEPTH);
  localparam int CNT_W = K + 2;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sel_o = cnt_q[K];
  assign rot_o = cnt_q[K+1] & cnt_q[K];

endmodule

// File: rtl/shift_reg.sv
// Clock-enabled shift register with synchronous reset; q_o is the oldest entry.
module shift_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (ce_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/fft_r22sdf_bfii.sv
// BF II butterfly of a radix-2^2 SDF stage: local control, -j rotation, valid-gated feedback delay, registered output.
module fft_r22sdf_bfii
  import fft_r22sdf_pkg::*;
#(
  parameter int DATA_WIDTH    = 25,
  parameter int SHIFT_REG_LEN = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic                         valid_o,
  output logic signed [DATA_WIDTH-1:0] z_re_o,
  output logic signed [DATA_WIDTH-1:0] z_im_o,
  output logic                         sel_o
);

  logic sel, rot;

  fft_r22sdf_ctr #(
    .DEPTH(SHIFT_REG_LEN)
  ) u_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (valid_i),
    .sel_o (sel),
    .rot_o (rot)
  );

  logic [2*DATA_WIDTH-1:0]      dlIn, dlOut;
  logic signed [DATA_WIDTH-1:0] fbRe, fbIm, xrRe, xrIm;
  logic signed [DATA_WIDTH-1:0] fbInRe, fbInIm;
  logic signed [DATA_WIDTH-1:0] zRe_d, zIm_d, zRe_q, zIm_q;
  logic                         sel_d, sel_q, valid_q;
  cpx_wide_t                    xWide, xRot;

  assign fbRe = dlOut[2*DATA_WIDTH-1:DATA_WIDTH];
  assign fbIm = dlOut[DATA_WIDTH-1:0];
  assign dlIn = {fbInRe, fbInIm};

  always_comb begin
    xWide.re = CPX_MAX_W'(x_re_i);
    xWide.im = CPX_MAX_W'(x_im_i);
    xRot     = rotMinusJ(xWide);
    xrRe     = x_re_i;
    xrIm     = x_im_i;
    if (rot) begin
      xrRe = DATA_WIDTH'(xRot.re);
      xrIm = DATA_WIDTH'(xRot.im);
    end
  end

  // Output and register hold their value on idle cycles so gaps never disturb the data stream.
  always_comb begin
    zRe_d  = zRe_q;
    zIm_d  = zIm_q;
    sel_d  = sel_q;
    fbInRe = xrRe;
    fbInIm = xrIm;
    if (valid_i) begin
      sel_d = sel;
      if (sel) begin
        zRe_d  = xrRe + fbRe;
        zIm_d  = xrIm + fbIm;
        fbInRe = fbRe - xrRe;
        fbInIm = fbIm - xrIm;
      end else begin
        zRe_d = fbRe;
        zIm_d = fbIm;
      end
    end
  end

  if (SHIFT_REG_LEN > INLINE_DELAY_MAX) begin : g_shift_reg
    shift_reg #(
      .WIDTH(2*DATA_WIDTH),
      .DEPTH(SHIFT_REG_LEN)
    ) u_delay (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ce_i  (valid_i),
      .d_i   (dlIn),
      .q_o   (dlOut)
    );
  end else begin : g_inline
    logic [2*DATA_WIDTH-1:0] delay_q [SHIFT_REG_LEN];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < SHIFT_REG_LEN; i++) delay_q[i] <= '0;
      end else if (valid_i) begin
        delay_q[0] <= dlIn;
        for (int i = 1; i < SHIFT_REG_LEN; i++) delay_q[i] <= delay_q[i-1];
      end
    end

    assign dlOut = delay_q[SHIFT_REG_LEN-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zRe_q   <= '0;
      zIm_q   <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      zRe_q   <= zRe_d;
      zIm_q   <= zIm_d;
      sel_q   <= sel_d;
      valid_q <= valid_i;
    end
  end

  assign z_re_o  = zRe_q;
  assign z_im_o  = zIm_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_fft_r22sdf_bfii.sv
// Self-checking bench: three BF II instances (L=2, L=1, L=64) share one stimulus stream and are each checked against a circular-buffer model.
module tb_fft_r22sdf_bfii;

  typedef struct {
    bit valid;
    int re;
    int im;
    int expRe;
    int expIm;
    bit expSel;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0;
  logic signed [15:0] xRe = '0;
  logic signed [15:0] xIm = '0;

  logic               vld [3];
  logic               sel [3];
  logic signed [15:0] zRe [3];
  logic signed [15:0] zIm [3];

  int compared = 0;
  int mismatched = 0;

  int      depthOf [3] = '{2, 1, 64};
  int      modelCnt [3];
  int      modelPtr [3];
  shortint bufRe [3][64];
  shortint bufIm [3][64];
  shortint expRe [3];
  shortint expIm [3];
  bit      expValid [3];
  bit      expSel [3];

  vec_t basicVec [10];
  vec_t l1Vec [5];

  always #5 clk = ~clk;

  fft_r22sdf_bfii #(.DATA_WIDTH(16), .SHIFT_REG_LEN(2)) dutA (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .x_re_i(xRe), .x_im_i(xIm),
    .valid_o(vld[0]), .z_re_o(zRe[0]), .z_im_o(zIm[0]), .sel_o(sel[0]));

  fft_r22sdf_bfii #(.DATA_WIDTH(16), .SHIFT_REG_LEN(1)) dutB (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .x_re_i(xRe), .x_im_i(xIm),
    .valid_o(vld[1]), .z_re_o(zRe[1]), .z_im_o(zIm[1]), .sel_o(sel[1]));

  fft_r22sdf_bfii #(.DATA_WIDTH(16), .SHIFT_REG_LEN(64)) dutC (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .x_re_i(xRe), .x_im_i(xIm),
    .valid_o(vld[2]), .z_re_o(zRe[2]), .z_im_o(zIm[2]), .sel_o(sel[2]));

  task automatic cmp(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      modelCnt[d] = 0;
      modelPtr[d] = 0;
      for (int i = 0; i < 64; i++) begin
        bufRe[d][i] = 0;
        bufIm[d][i] = 0;
      end
      expRe[d] = 0;
      expIm[d] = 0;
      expValid[d] = 1'b0;
      expSel[d] = 1'b0;
    end
  endtask

  // Window quarter q = (n mod 4L)/L: odd quarters add/subtract, quarter 3 pre-rotates by -j.
  task automatic modelStep(input bit v, input int re, input int im);
    for (int d = 0; d < 3; d++) begin
      int len, quarter;
      shortint xr, xi, fr, fi;
      expValid[d] = v;
      if (v) begin
        len = depthOf[d];
        quarter = (modelCnt[d] % (4 * len)) / len;
        if (quarter == 3) begin
          xr = shortint'(im);
          xi = shortint'(-re);
        end else begin
          xr = shortint'(re);
          xi = shortint'(im);
        end
        fr = bufRe[d][modelPtr[d]];
        fi = bufIm[d][modelPtr[d]];
        if (quarter % 2 == 1) begin
          expRe[d] = shortint'(xr + fr);
          expIm[d] = shortint'(xi + fi);
          bufRe[d][modelPtr[d]] = shortint'(fr - xr);
          bufIm[d][modelPtr[d]] = shortint'(fi - xi);
        end else begin
          expRe[d] = fr;
          expIm[d] = fi;
          bufRe[d][modelPtr[d]] = xr;
          bufIm[d][modelPtr[d]] = xi;
        end
        expSel[d] = (quarter % 2 == 1);
        modelPtr[d] = (modelPtr[d] + 1) % len;
        modelCnt[d] = (modelCnt[d] + 1) % (4 * len);
      end
    end
  endtask

  task automatic checkOutput();
    for (int d = 0; d < 3; d++) begin
      cmp($sformatf("dut%0d valid_o", d), int'(vld[d]), int'(expValid[d]));
      cmp($sformatf("dut%0d z_re_o", d), int'(zRe[d]), int'(expRe[d]));
      cmp($sformatf("dut%0d z_im_o", d), int'(zIm[d]), int'(expIm[d]));
      cmp($sformatf("dut%0d sel_o", d), int'(sel[d]), int'(expSel[d]));
    end
  endtask

  task automatic applyStimulus(input bit v, input int re, input int im);
    valid = v;
    xRe = 16'(re);
    xIm = 16'(im);
    @(posedge clk);
    modelStep(v, int'(16'(re)), int'(16'(im)));
    #1;
    checkOutput();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    valid = 1'b0;
    xRe = '0;
    xIm = '0;
    @(posedge clk);
    modelReset();
    #1;
    rst = 1'b0;
    checkOutput();
  endtask

  task automatic checkVec(input string name, input int d, input vec_t v);
    cmp({name, " z_re"}, int'(zRe[d]), v.expRe);
    cmp({name, " z_im"}, int'(zIm[d]), v.expIm);
    cmp({name, " sel"}, int'(sel[d]), int'(v.expSel));
    cmp({name, " valid"}, int'(vld[d]), 1);
  endtask

  initial begin
    basicVec[0] = '{1'b1, 1, 0, 0, 0, 1'b0};
    basicVec[1] = '{1'b1, 2, 0, 0, 0, 1'b0};
    basicVec[2] = '{1'b1, 3, 0, 4, 0, 1'b1};
    basicVec[3] = '{1'b1, 4, 0, 6, 0, 1'b1};
    basicVec[4] = '{1'b1, 5, 0, -2, 0, 1'b0};
    basicVec[5] = '{1'b1, 6, 0, -2, 0, 1'b0};
    basicVec[6] = '{1'b1, 7, 0, 5, -7, 1'b1};
    basicVec[7] = '{1'b1, 8, 0, 6, -8, 1'b1};
    basicVec[8] = '{1'b1, 0, 0, 5, 7, 1'b0};
    basicVec[9] = '{1'b1, 0, 0, 6, 8, 1'b0};

    l1Vec[0] = '{1'b1, 1, 2, 0, 0, 1'b0};
    l1Vec[1] = '{1'b1, 3, 4, 4, 6, 1'b1};
    l1Vec[2] = '{1'b1, 5, 6, -2, -2, 1'b0};
    l1Vec[3] = '{1'b1, 7, 8, 13, -1, 1'b1};
    l1Vec[4] = '{1'b1, 0, 0, -3, 13, 1'b0};

    modelReset();
    applyReset();
    cmp("reset z_re", int'(zRe[0]), 0);
    cmp("reset valid", int'(vld[0]), 0);

    $display("[TB] basic window");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(basicVec[i].valid, basicVec[i].re, basicVec[i].im);
      checkVec($sformatf("basic[%0d]", i), 0, basicVec[i]);
    end
    applyStimulus(0, 0, 0);
    cmp("basic valid drop", int'(vld[0]), 0);

    $display("[TB] gapped valid");
    applyReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, basicVec[i].re, basicVec[i].im);
      checkVec($sformatf("gap[%0d]", i), 0, basicVec[i]);
      for (int g = 0; g < 3; g++) begin
        applyStimulus(0, 99, -99);
        cmp("gap hold z_re", int'(zRe[0]), basicVec[i].expRe);
        cmp("gap hold z_im", int'(zIm[0]), basicVec[i].expIm);
        cmp("gap valid", int'(vld[0]), 0);
      end
    end

    $display("[TB] reset mid-frame");
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 100 + i, -i);
    applyReset();
    cmp("midreset valid", int'(vld[0]), 0);
    cmp("midreset z_re", int'(zRe[0]), 0);
    cmp("midreset z_im", int'(zIm[0]), 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, basicVec[i].re, basicVec[i].im);
      checkVec($sformatf("replay[%0d]", i), 0, basicVec[i]);
    end

    $display("[TB] wraparound");
    applyReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, 1);
      if (i == 8) cmp("wrap sel at window start", int'(sel[0]), 0);
      if (i == 10) cmp("wrap sel at second quarter", int'(sel[0]), 1);
    end

    $display("[TB] overflow");
    applyReset();
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 32767, 0);
    cmp("overflow sum", int'(zRe[0]), -32768);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    cmp("overflow feedback", int'(zRe[0]), -32766);

    $display("[TB] depth one");
    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, l1Vec[i].re, l1Vec[i].im);
      checkVec($sformatf("l1[%0d]", i), 1, l1Vec[i]);
    end

    $display("[TB] negate most-negative");
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(1, (i >= 6) ? -32768 : 0, 0);
    cmp("neg wrap z_im", int'(zIm[0]), -32768);

    $display("[TB] random");
    applyReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) applyReset();
      else applyStimulus(($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)),
                         int'($urandom_range(0, 65535)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
